// File: rtl/alu_cmd_sequencer_if.sv
// Signal bundle between alu_cmd_sequencer and its environment: host command channel,
// ALU operand/result port and host response channel.
interface alu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [1:0]  cmd_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [1:0]  alu_op_sel;
  logic        alu_load;
  logic [15:0] alu_result;
  logic        alu_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_op;
  logic [7:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_done, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op_sel, alu_load,
           rsp_valid, rsp_data, rsp_op, rsp_tag, rsp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_done, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op_sel, alu_load,
           rsp_valid, rsp_data, rsp_op, rsp_tag, rsp_err, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers host ALU commands, issues them one at a time to the ALU and returns tagged results
// in order; a watchdog turns an ALU that never completes into an error response.

module alu_cmd_sequencer_chk #(
  parameter int DEPTH = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  input logic                     alu_load,
  input logic                     rsp_valid,
  input logic                     rsp_ready,
  input logic [15:0]              rsp_data,
  input logic [7:0]               rsp_tag,
  input logic [7:0]               alu_a,
  input logic [7:0]               alu_b,
  input logic [1:0]               alu_op_sel,
  input logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  a_load_excl_rsp: assert property (@(posedge clk) disable iff (!reset_n)
    !(alu_load && rsp_valid));

  a_load_single: assert property (@(posedge clk) disable iff (!reset_n)
    alu_load |=> !alu_load);

  a_rsp_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_tag)
                                   && $stable(alu_a) && $stable(alu_b) && $stable(alu_op_sel)));

  a_count_max: assert property (@(posedge clk) disable iff (!reset_n)
    count <= DEPTH_C);
endmodule

module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 reset_n,
  alu_cmd_sequencer_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       fifo_a_q  [DEPTH];
  logic [7:0]       fifo_b_q  [DEPTH];
  logic [1:0]       fifo_op_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       tag_q, tag_d;
  logic [7:0]       wd_q, wd_d;
  logic [7:0]       wd_inc;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             cmd_ready;

  assign cmd_ready  = (count_q < DEPTH_C);
  assign fifo_empty = (count_q == CNT_ZERO);
  assign push       = bus.cmd_valid && cmd_ready;
  assign wd_inc     = wd_q + 8'd1;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Sequencer FSM next-state, operand capture, watchdog and response capture
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    tag_d      = tag_q;
    wd_d       = wd_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          alu_a_d  = fifo_a_q[rd_ptr_q];
          alu_b_d  = fifo_b_q[rd_ptr_q];
          alu_op_d = fifo_op_q[rd_ptr_q];
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        wd_d    = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // wd_inc counts WAIT cycles including this one; done takes priority over timeout
        wd_d = wd_inc;
        if (bus.alu_done) begin
          rsp_data_d = bus.alu_result;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wd_inc == TIMEOUT_C) begin
          rsp_data_d = 16'hFFFF;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          state_d    = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          tag_d   = tag_q + 8'd1;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      alu_a_q    <= 8'd0;
      alu_b_q    <= 8'd0;
      alu_op_q   <= 2'd0;
      rsp_data_q <= 16'd0;
      rsp_err_q  <= 1'b0;
      tag_q      <= 8'd0;
      wd_q       <= 8'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      tag_q      <= tag_d;
      wd_q       <= wd_d;
    end
  end

  // Command FIFO storage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_a_q[i]  <= 8'd0;
        fifo_b_q[i]  <= 8'd0;
        fifo_op_q[i] <= 2'd0;
      end
    end else if (push) begin
      fifo_a_q[wr_ptr_q]  <= bus.cmd_a;
      fifo_b_q[wr_ptr_q]  <= bus.cmd_b;
      fifo_op_q[wr_ptr_q] <= bus.cmd_op;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op_sel = alu_op_q;
  assign bus.alu_load   = (state_q == ISSUE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_op     = alu_op_q;
  assign bus.rsp_tag    = tag_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (state_q != IDLE) || !fifo_empty;

  alu_cmd_sequencer_chk #(.DEPTH(DEPTH)) u_chk (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_load   (bus.alu_load),
    .rsp_valid  (bus.rsp_valid),
    .rsp_ready  (bus.rsp_ready),
    .rsp_data   (bus.rsp_data),
    .rsp_tag    (bus.rsp_tag),
    .alu_a      (bus.alu_a),
    .alu_b      (bus.alu_b),
    .alu_op_sel (bus.alu_op_sel),
    .count      (count_q)
  );
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a configurable-latency ALU model (TIMEOUT=10).
module tb_alu_cmd_sequencer;
  localparam int TMO = 10;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  op;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         n_rsp = 0;
  exp_t       sb[$];
  logic [7:0] exp_tag = 8'd0;
  int         alu_delay = 1;
  bit         spur = 1'b0;
  int         stray_req = 0;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0:    return 16'(a) + 16'(b);
      2'd1:    return 16'(a) - 16'(b);
      2'd2:    return 16'(a) * 16'(b);
      default: return (b == 8'd0) ? 16'hFFFF : 16'(a / b);
    endcase
  endfunction

  // ALU model: done pulses alu_delay cycles after load (0 = never)
  initial begin
    int cnt;
    int stray_seen;
    logic [15:0] pend;
    cnt = 0; stray_seen = 0; pend = 16'h0000;
    bus.alu_done = 1'b0;
    bus.alu_result = 16'h0000;
    forever begin
      @(posedge clk); #1;
      bus.alu_done = 1'b0;
      if (bus.busy !== 1'b1) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.alu_done = 1'b1;
          bus.alu_result = pend;
        end
      end
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        bus.alu_done = 1'b1;
        bus.alu_result = 16'hBEEF;
      end
      if (bus.alu_load === 1'b1) begin
        pend = alu_f(bus.alu_a, bus.alu_b, bus.alu_op_sel);
        cnt = alu_delay;
        if (spur) begin
          bus.alu_done = 1'b1;
          bus.alu_result = 16'hDEAD;
        end
      end
    end
  end

  // Response scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected got data=%h tag=%0d, no response expected",
                   bus.rsp_data, bus.rsp_tag);
        end else begin
          e = sb.pop_front();
          n_rsp++;
          if ({bus.rsp_data, bus.rsp_op, bus.rsp_tag, bus.rsp_err} !== {e.data, e.op, e.tag, e.err}) begin
            bad++;
            $display("FAIL rsp_check got data=%h op=%0d tag=%0d err=%0d want data=%h op=%0d tag=%0d err=%0d",
                     bus.rsp_data, bus.rsp_op, bus.rsp_tag, bus.rsp_err, e.data, e.op, e.tag, e.err);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    exp_t e;
    e.err  = (alu_delay == 0) || (alu_delay > TMO);
    e.data = e.err ? 16'hFFFF : alu_f(a, b, op);
    e.op   = op;
    e.tag  = exp_tag;
    exp_tag = exp_tag + 8'd1;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL cmd_accept got cmd_ready=%b for 300 cycles want 1", bus.cmd_ready);
    end else begin
      push_exp(a, b, op);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain got busy=%b pending=%0d want busy=0 pending=0", bus.busy, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete();
    exp_tag = 8'd0;
    @(negedge clk);
    total += 5;
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
    if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    if (bus.alu_load !== 1'b0) begin bad++; $display("FAIL reset_alu_load got %b want 0", bus.alu_load); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if ({bus.alu_a, bus.alu_b, bus.alu_op_sel, bus.rsp_data, bus.rsp_op, bus.rsp_tag, bus.rsp_err} !== 45'd0) begin
      bad++;
      $display("FAIL reset_outputs got a=%h b=%h op=%0d data=%h rop=%0d tag=%0d err=%b want all 0",
               bus.alu_a, bus.alu_b, bus.alu_op_sel, bus.rsp_data, bus.rsp_op, bus.rsp_tag, bus.rsp_err);
    end
  endtask

  task automatic test_add();
    alu_delay = 1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_a = 8'h12; bus.cmd_b = 8'h34; bus.cmd_op = 2'd0;
    @(negedge clk);  // cycle 0
    total++;
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL add_c0_ready got %b want 1", bus.cmd_ready); end
    push_exp(8'h12, 8'h34, 2'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);  // cycle 1
    total++;
    if ({bus.alu_load, bus.busy} !== 2'b01) begin
      bad++; $display("FAIL add_c1 got load=%b busy=%b want load=0 busy=1", bus.alu_load, bus.busy);
    end
    @(negedge clk);  // cycle 2
    total++;
    if ({bus.alu_load, bus.alu_a, bus.alu_b, bus.alu_op_sel} !== {1'b1, 8'h12, 8'h34, 2'd0}) begin
      bad++; $display("FAIL add_c2_load got load=%b a=%h b=%h op=%0d want load=1 a=12 b=34 op=0",
                      bus.alu_load, bus.alu_a, bus.alu_b, bus.alu_op_sel);
    end
    @(negedge clk);  // cycle 3
    total++;
    if ({bus.alu_load, bus.rsp_valid} !== 2'b00) begin
      bad++; $display("FAIL add_c3 got load=%b rsp_valid=%b want 0 0", bus.alu_load, bus.rsp_valid);
    end
    @(negedge clk);  // cycle 4
    total++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {1'b1, 16'h0046, 8'd0, 1'b0}) begin
      bad++; $display("FAIL add_c4_rsp got valid=%b data=%h tag=%0d err=%b want 1 0046 0 0",
                      bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_err);
    end
    @(negedge clk);  // cycle 5
    total++;
    if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL add_c5_valid got %b want 0", bus.rsp_valid); end
    wait_idle(20);
  endtask

  task automatic test_fill();
    bit saw_ready;
    alu_delay = 0;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_cmd(8'(8'h20 + i), 8'(8'h03 + i), 2'(i));
    saw_ready = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_a = 8'h55; bus.cmd_b = 8'h66; bus.cmd_op = 2'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cmd_ready !== 1'b0) saw_ready = 1'b1;
      @(posedge clk); #1;
    end
    total += 2;
    if (saw_ready) begin bad++; $display("FAIL fill_full got cmd_ready=1 while full want 0"); end
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {1'b1, 1'b1, 16'hFFFF}) begin
      bad++; $display("FAIL fill_stalled_rsp got valid=%b err=%b data=%h want 1 1 ffff",
                      bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    bus.rsp_ready = 1'b1;
    send_cmd(8'h55, 8'h66, 2'd1);
    wait_idle(200);
  endtask

  task automatic test_timeout();
    int k;
    bit found;
    alu_delay = 0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    send_cmd(8'h09, 8'h07, 2'd2);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.alu_load === 1'b1) begin found = 1'b1; break; end
    end
    k = 0;
    if (found) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        k++;
        if (bus.rsp_valid === 1'b1) break;
      end
    end
    total += 2;
    if (k != 11) begin bad++; $display("FAIL timeout_latency got %0d cycles after load want 11", k); end
    if ({bus.rsp_data, bus.rsp_err} !== {16'hFFFF, 1'b1}) begin
      bad++; $display("FAIL timeout_rsp got data=%h err=%b want ffff 1", bus.rsp_data, bus.rsp_err);
    end
    wait_idle(30);
    alu_delay = 2;
    send_cmd(8'h30, 8'h10, 2'd1);
    wait_idle(30);
  endtask

  task automatic test_backpressure();
    bit found;
    alu_delay = 6;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    send_cmd(8'h0F, 8'h11, 2'd2);
    send_cmd(8'h05, 8'h07, 2'd1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL bp_rsp_wait got rsp_valid=0 for 40 cycles want 1"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({bus.rsp_data, bus.alu_a, bus.alu_b, bus.alu_op_sel, bus.alu_load, bus.rsp_valid}
          !== {16'h00FF, 8'h0F, 8'h11, 2'd2, 1'b0, 1'b1}) begin
        bad++; $display("FAIL bp_hold got data=%h a=%h b=%h op=%0d load=%b valid=%b want 00ff 0f 11 2 0 1",
                        bus.rsp_data, bus.alu_a, bus.alu_b, bus.alu_op_sel, bus.alu_load, bus.rsp_valid);
      end
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_idle(60);
  endtask

  task automatic test_reset_mid_wait();
    alu_delay = 0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    send_cmd(8'h64, 8'h05, 2'd3);
    send_cmd(8'h01, 8'h02, 2'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.alu_load === 1'b1) break;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.delete();
    exp_tag = 8'd0;
    stray_req++;
    @(negedge clk);
    total++;
    if ({bus.rsp_valid, bus.alu_load, bus.cmd_ready, bus.busy} !== 4'b0010) begin
      bad++; $display("FAIL midreset_state got valid=%b load=%b ready=%b busy=%b want 0 0 1 0",
                      bus.rsp_valid, bus.alu_load, bus.cmd_ready, bus.busy);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
        bad++; $display("FAIL midreset_stray got valid=%b busy=%b want 0 0", bus.rsp_valid, bus.busy);
      end
    end
    @(posedge clk); #1;
    alu_delay = 1;
    send_cmd(8'h64, 8'h05, 2'd3);
    wait_idle(30);
  endtask

  task automatic test_tag_wrap();
    int start;
    test_reset();
    alu_delay = 1;
    spur = 1'b1;
    bus.rsp_ready = 1'b1;
    start = n_rsp;
    @(posedge clk); #1;
    for (int i = 0; i < 257; i++) send_cmd(8'($urandom), 8'($urandom), 2'($urandom));
    wait_idle(100);
    spur = 1'b0;
    total++;
    if (n_rsp - start != 257) begin
      bad++; $display("FAIL wrap_count got %0d responses want 257", n_rsp - start);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 8'h00;
    bus.cmd_b = 8'h00;
    bus.cmd_op = 2'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_fill();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_tag_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got simulation still running want finished");
    $fatal(1);
  end
endmodule
